// File: rtl/cpu_mul_pkg.sv
// Shared types for the pipelined multiply unit: operation encoding and op helpers.
// High-half support in the users of this package is controlled by CPU_MUL_HIGH_EN.
package cpu_mul_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        MUL_LO  = 2'b00,
        MUL_XUU = 2'b01,
        MUL_XSU = 2'b10,
        MUL_XSS = 2'b11
    } mul_op_t;

    // Every op except MUL returns the upper half of the double-width product.
    function automatic logic is_high_op(input mul_op_t op);
        return op != MUL_LO;
    endfunction

endpackage

// File: rtl/cpu_mul_if.sv
// Operand/result handshake bundle of the multiply unit; master is the CPU side, slave the unit.
interface cpu_mul_if
    import cpu_mul_pkg::*;
#(
    parameter int DATA_W = 32
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    mul_op_t           in_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_op,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_op,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result
    );

endinterface

// File: rtl/cpu_mul_pp.sv
// Combinational half-width partial products and signed correction term.
// p_hh and corr exist only when CPU_MUL_HIGH_EN is defined.
module cpu_mul_pp
    import cpu_mul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
`ifdef CPU_MUL_HIGH_EN
    input  mul_op_t           op,
    output logic [DATA_W-1:0] p_hh,
    output logic [DATA_W-1:0] corr,
`endif
    output logic [DATA_W-1:0] p_ll,
    output logic [DATA_W-1:0] p_lh,
    output logic [DATA_W-1:0] p_hl
);

    localparam int H = DATA_W / 2;

    // Halves are zero-extended to full width so each product is exact without truncation.
    logic [DATA_W-1:0] al;
    logic [DATA_W-1:0] ah;
    logic [DATA_W-1:0] bl;
    logic [DATA_W-1:0] bh;

    assign al = {{H{1'b0}}, a[H-1:0]};
    assign ah = {{H{1'b0}}, a[DATA_W-1:H]};
    assign bl = {{H{1'b0}}, b[H-1:0]};
    assign bh = {{H{1'b0}}, b[DATA_W-1:H]};

    assign p_ll = al * bl;
    assign p_lh = al * bh;
    assign p_hl = ah * bl;

`ifdef CPU_MUL_HIGH_EN
    assign p_hh = ah * bh;

    // Subtracting this from the unsigned high half yields the signed high half.
    always_comb begin
        corr = '0;
        case (op)
            MUL_XSS: corr = (a[DATA_W-1] ? b : '0) + (b[DATA_W-1] ? a : '0);
            MUL_XSU: corr = a[DATA_W-1] ? b : '0;
            default: corr = '0;
        endcase
    end
`endif

endmodule

// File: rtl/cpu_mul_pipe.sv
// Two-stage pipelined DATA_W x DATA_W multiplier with valid/ready back-pressure.
// Define CPU_MUL_HIGH_EN to build the high-half ops (MULXUU/MULXSU/MULXSS); otherwise all ops run as MUL.
module cpu_mul_pipe
    import cpu_mul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic     clk,
    input logic     reset_n,
    cpu_mul_if.slave bus
);

    localparam int H = DATA_W / 2;

    typedef struct packed {
        logic [DATA_W-1:0] p_ll;
        logic [DATA_W-1:0] p_lh;
        logic [DATA_W-1:0] p_hl;
`ifdef CPU_MUL_HIGH_EN
        logic [DATA_W-1:0] p_hh;
        logic [DATA_W-1:0] corr;
        mul_op_t           op;
`endif
    } s1_data_t;

    logic [DATA_W-1:0] pp_ll;
    logic [DATA_W-1:0] pp_lh;
    logic [DATA_W-1:0] pp_hl;
    s1_data_t          s1_d;
    s1_data_t          s1_q;
    logic              s1_valid;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_result_q;
    logic [DATA_W-1:0] result;
    logic              s2_load;
    logic              accept;

`ifdef CPU_MUL_HIGH_EN
    logic [DATA_W-1:0]   pp_hh;
    logic [DATA_W-1:0]   pp_corr;
    logic [DATA_W:0]     mid;
    logic [2*DATA_W-1:0] prod;

    cpu_mul_pp #(.DATA_W(DATA_W)) u_pp (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .op   (bus.in_op),
        .p_hh (pp_hh),
        .corr (pp_corr),
        .p_ll (pp_ll),
        .p_lh (pp_lh),
        .p_hl (pp_hl)
    );

    always_comb begin
        s1_d      = '0;
        s1_d.p_ll = pp_ll;
        s1_d.p_lh = pp_lh;
        s1_d.p_hl = pp_hl;
        s1_d.p_hh = pp_hh;
        s1_d.corr = pp_corr;
        s1_d.op   = bus.in_op;
    end

    // Middle sum keeps its carry bit so the high half sees every cross-term carry.
    assign mid  = {1'b0, s1_q.p_lh} + {1'b0, s1_q.p_hl};
    assign prod = {s1_q.p_hh, s1_q.p_ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};

    assign result = is_high_op(s1_q.op) ? (prod[2*DATA_W-1:DATA_W] - s1_q.corr)
                                        : prod[DATA_W-1:0];
`else
    logic [DATA_W-1:0] mid_lo;
    logic              unused_op;
    logic              unused_mid_hi;

    cpu_mul_pp #(.DATA_W(DATA_W)) u_pp (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .p_ll (pp_ll),
        .p_lh (pp_lh),
        .p_hl (pp_hl)
    );

    always_comb begin
        s1_d      = '0;
        s1_d.p_ll = pp_ll;
        s1_d.p_lh = pp_lh;
        s1_d.p_hl = pp_hl;
    end

    // Only the low half is produced, so cross-term bits at or above DATA_W fall away.
    assign mid_lo        = s1_q.p_lh + s1_q.p_hl;
    assign result        = s1_q.p_ll + {mid_lo[H-1:0], {H{1'b0}}};
    assign unused_op     = ^bus.in_op;
    assign unused_mid_hi = ^mid_lo[DATA_W-1:H];
`endif

    assign s2_load      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = reset_n && (!s1_valid || s2_load);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;

    // Stage 1 refills whenever it can move on; stage 2 loads whenever its result is gone or leaving.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid     <= 1'b0;
            s1_q         <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (accept) begin
                s1_q <= s1_d;
            end
            if (s2_load) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    out_result_q <= result;
                end
            end
        end
    end

endmodule
